// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Decode-side request and hazard/forwarding response bundle.
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [REG_AW-1:0] d_rd;
    logic [1:0]        d_dst_sel;
    logic [T_W-1:0]    d_tnew;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic              stall;
    logic [1:0]        fwd_d_rs;
    logic [1:0]        fwd_d_rt;
    logic [1:0]        fwd_e_rs;
    logic [1:0]        fwd_e_rt;
    logic              fwd_m_rt;
    logic [REG_AW-1:0] w_dst;
    logic              w_we;

    modport master (
        output d_rs, d_rt, d_rd, d_dst_sel, d_tnew, d_tuse_rs, d_tuse_rt,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, w_dst, w_we
    );

    modport slave (
        input  d_rs, d_rt, d_rd, d_dst_sel, d_tnew, d_tuse_rs, d_tuse_rt,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, w_dst, w_we
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Tnew/Tuse stall generation and operand forwarding for F/D/E/M/W.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0]        c_SEL_RT    = 2'b00;
    localparam logic [1:0]        c_SEL_RD    = 2'b01;
    localparam logic [1:0]        c_SEL_LINK  = 2'b10;
    localparam logic [T_W-1:0]    c_TUSE_NONE = {T_W{1'b1}};
    localparam logic [REG_AW-1:0] c_LINK_REG  = {REG_AW{1'b1}};

    logic [REG_AW-1:0] e_rs_q, e_rt_q, e_dst_q;
    logic [T_W-1:0]    e_tnew_q;
    logic [REG_AW-1:0] m_rt_q, m_dst_q;
    logic [T_W-1:0]    m_tnew_q;
    logic [REG_AW-1:0] w_dst_q;

    logic [REG_AW-1:0] e_rs_d, e_rt_d, e_dst_d;
    logic [T_W-1:0]    e_tnew_d;
    logic [T_W-1:0]    m_tnew_d;
    logic [REG_AW-1:0] dst_dec;
    logic              stall_rs, stall_rt, stall;

    function automatic logic op_stall(
        input logic [REG_AW-1:0] r,
        input logic [T_W-1:0]    tuse,
        input logic [REG_AW-1:0] e_dst,
        input logic [T_W-1:0]    e_tnew,
        input logic [REG_AW-1:0] m_dst,
        input logic [T_W-1:0]    m_tnew
    );
        op_stall = (r != '0) && (tuse != c_TUSE_NONE) &&
                   (((e_dst == r) && (e_tnew > tuse)) ||
                    ((m_dst == r) && (m_tnew > tuse)));
    endfunction

    // Nearer producer is tested first so the youngest matching result wins.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] near_dst,
        input logic              near_ready,
        input logic [REG_AW-1:0] far_dst,
        input logic              far_ready
    );
        fwd_sel = 2'b00;
        if (r != '0) begin
            if ((near_dst == r) && near_ready) begin
                fwd_sel = 2'b01;
            end else if ((far_dst == r) && far_ready) begin
                fwd_sel = 2'b10;
            end
        end
    endfunction

    always_comb begin
        dst_dec = '0;
        case (hz.d_dst_sel)
            c_SEL_RT:   dst_dec = hz.d_rt;
            c_SEL_RD:   dst_dec = hz.d_rd;
            c_SEL_LINK: dst_dec = c_LINK_REG;
            default:    dst_dec = '0;
        endcase
    end

    always_comb begin
        stall_rs = op_stall(hz.d_rs, hz.d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        stall_rt = op_stall(hz.d_rt, hz.d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        stall    = stall_rs | stall_rt;
    end

    always_comb begin
        e_rs_d   = '0;
        e_rt_d   = '0;
        e_dst_d  = '0;
        e_tnew_d = '0;
        if (!stall) begin
            e_rs_d   = hz.d_rs;
            e_rt_d   = hz.d_rt;
            e_dst_d  = dst_dec;
            e_tnew_d = hz.d_tnew;
        end
        m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - T_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_dst_q  <= '0;
            e_tnew_q <= '0;
            m_rt_q   <= '0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            w_dst_q  <= '0;
        end else begin
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            m_rt_q   <= e_rt_q;
            m_dst_q  <= e_dst_q;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= m_dst_q;
        end
    end

    // W results are always complete, so the W producer is unconditionally ready.
    assign hz.stall    = stall;
    assign hz.fwd_d_rs = fwd_sel(hz.d_rs, e_dst_q, (e_tnew_q == '0), m_dst_q, (m_tnew_q == '0));
    assign hz.fwd_d_rt = fwd_sel(hz.d_rt, e_dst_q, (e_tnew_q == '0), m_dst_q, (m_tnew_q == '0));
    assign hz.fwd_e_rs = fwd_sel(e_rs_q, m_dst_q, (m_tnew_q == '0), w_dst_q, 1'b1);
    assign hz.fwd_e_rt = fwd_sel(e_rt_q, m_dst_q, (m_tnew_q == '0), w_dst_q, 1'b1);
    assign hz.fwd_m_rt = (m_rt_q != '0) && (w_dst_q == m_rt_q);
    assign hz.w_dst    = w_dst_q;
    assign hz.w_we     = (w_dst_q != '0);
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed and random stimulus against an in-flight instruction model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .T_W(2)) bus ();
    hazard_ctrl #(.REG_AW(5), .T_W(2)) dut (.clk(clk), .reset(reset), .hz(bus.slave));

    // Each slot keeps the Tnew the instruction had when it left D; slot 0=E, 1=M, 2=W.
    typedef struct {
        int rs;
        int rt;
        int dst;
        int tnew0;
    } slot_t;

    slot_t st [3];
    int    n_pass  = 0;
    int    n_total = 0;
    int    run     = 0;
    int    max_run = 0;
    int    exp_stall;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int remaining(input int k);
        return (st[k].tnew0 > k) ? st[k].tnew0 - k : 0;
    endfunction

    function automatic int dst_of(input int rt, input int rd, input int sel);
        case (sel)
            0:       return rt;
            1:       return rd;
            2:       return 31;
            default: return 0;
        endcase
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) st[k] = '{rs: 0, rt: 0, dst: 0, tnew0: 0};
    endtask

    task automatic compare();
        int ops[2], tuse[2], eops[2], fd[2], fe[2], fm;
        ops[0]  = int'(bus.d_rs);      ops[1]  = int'(bus.d_rt);
        tuse[0] = int'(bus.d_tuse_rs); tuse[1] = int'(bus.d_tuse_rt);
        eops[0] = st[0].rs;            eops[1] = st[0].rt;
        exp_stall = 0;
        for (int o = 0; o < 2; o++) begin
            if (ops[o] != 0 && tuse[o] != 3)
                for (int k = 0; k < 2; k++)
                    if (st[k].dst == ops[o] && remaining(k) > tuse[o]) exp_stall = 1;
            fd[o] = 0;
            if (ops[o] != 0 && st[0].dst == ops[o] && remaining(0) == 0) fd[o] = 1;
            else if (ops[o] != 0 && st[1].dst == ops[o] && remaining(1) == 0) fd[o] = 2;
            fe[o] = 0;
            if (eops[o] != 0 && st[1].dst == eops[o] && remaining(1) == 0) fe[o] = 1;
            else if (eops[o] != 0 && st[2].dst == eops[o]) fe[o] = 2;
        end
        fm = (st[1].rt != 0 && st[2].dst == st[1].rt) ? 1 : 0;
        check("stall",    int'(bus.stall),    exp_stall);
        check("fwd_d_rs", int'(bus.fwd_d_rs), fd[0]);
        check("fwd_d_rt", int'(bus.fwd_d_rt), fd[1]);
        check("fwd_e_rs", int'(bus.fwd_e_rs), fe[0]);
        check("fwd_e_rt", int'(bus.fwd_e_rt), fe[1]);
        check("fwd_m_rt", int'(bus.fwd_m_rt), fm);
        check("w_dst",    int'(bus.w_dst),    st[2].dst);
        check("w_we",     int'(bus.w_we),     (st[2].dst != 0) ? 1 : 0);
        run = bus.stall ? run + 1 : 0;
        if (run > max_run) max_run = run;
    endtask

    task automatic advance();
        st[2] = st[1];
        st[1] = st[0];
        if (exp_stall != 0) st[0] = '{rs: 0, rt: 0, dst: 0, tnew0: 0};
        else st[0] = '{rs: int'(bus.d_rs), rt: int'(bus.d_rt),
                       dst: dst_of(int'(bus.d_rt), int'(bus.d_rd), int'(bus.d_dst_sel)),
                       tnew0: int'(bus.d_tnew)};
    endtask

    task automatic set_in(input int rs, input int rt, input int rd, input int sel,
                          input int tnew, input int tur, input int tut);
        bus.d_rs      = 5'(rs);
        bus.d_rt      = 5'(rt);
        bus.d_rd      = 5'(rd);
        bus.d_dst_sel = 2'(sel);
        bus.d_tnew    = 2'(tnew);
        bus.d_tuse_rs = 2'(tur);
        bus.d_tuse_rt = 2'(tut);
    endtask

    // Present one D-stage instruction for one cycle; the model follows the edge.
    task automatic drive(input int rs, input int rt, input int rd, input int sel,
                         input int tnew, input int tur, input int tut);
        @(negedge clk);
        set_in(rs, rt, rd, sel, tnew, tur, tut);
        #1;
        compare();
        advance();
    endtask

    task automatic nop();
        drive(0, 0, 0, 3, 0, 3, 3);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) nop();
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 8;
            2:       return 9;
            3:       return 31;
            4:       return 1;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        clear_model();
        set_in(0, 0, 0, 3, 0, 3, 3);
        #2;
        check("rst_stall", int'(bus.stall), 0);
        check("rst_fwd",   int'({bus.fwd_d_rs, bus.fwd_d_rt, bus.fwd_e_rs, bus.fwd_e_rt, bus.fwd_m_rt}), 0);
        check("rst_w_dst", int'(bus.w_dst), 0);
        check("rst_w_we",  int'(bus.w_we), 0);
        @(negedge clk);
        reset = 1'b1;

        // ALU dependency chain
        drive(1, 2, 8, 1, 1, 1, 1);
        drive(8, 8, 9, 1, 1, 1, 1);
        check("alu_nostall", int'(bus.stall), 0);
        drive(8, 0, 0, 3, 0, 1, 3);
        check("alu_fe_rs", int'(bus.fwd_e_rs), 1);
        check("alu_fe_rt", int'(bus.fwd_e_rt), 1);
        nop();
        check("alu_fe_rs_w", int'(bus.fwd_e_rs), 2);

        // Load-use: one bubble, then W forwarding into E
        flush();
        drive(1, 8, 0, 0, 2, 1, 3);
        drive(8, 8, 9, 1, 1, 1, 1);
        check("lu_stall1", int'(bus.stall), 1);
        drive(8, 8, 9, 1, 1, 1, 1);
        check("lu_stall2", int'(bus.stall), 0);
        nop();
        check("lu_fe_rs", int'(bus.fwd_e_rs), 2);
        check("lu_fe_rt", int'(bus.fwd_e_rt), 2);

        // Branch after load: two stall cycles
        flush();
        drive(1, 8, 0, 0, 2, 1, 3);
        drive(8, 0, 0, 3, 0, 0, 0);
        check("bl_stall1", int'(bus.stall), 1);
        drive(8, 0, 0, 3, 0, 0, 0);
        check("bl_stall2", int'(bus.stall), 1);
        drive(8, 0, 0, 3, 0, 0, 0);
        check("bl_stall3", int'(bus.stall), 0);

        // Branch after ALU, then jal/jr
        flush();
        drive(1, 2, 9, 1, 1, 1, 1);
        drive(9, 0, 0, 3, 0, 0, 0);
        check("ba_stall1", int'(bus.stall), 1);
        drive(9, 0, 0, 3, 0, 0, 0);
        check("ba_stall2", int'(bus.stall), 0);
        check("ba_fd_rs",  int'(bus.fwd_d_rs), 2);
        drive(0, 0, 0, 2, 0, 3, 3);
        drive(31, 0, 0, 3, 0, 0, 3);
        check("jr_stall", int'(bus.stall), 0);
        check("jr_fd_rs", int'(bus.fwd_d_rs), 1);

        // $0 destination and no-write select
        flush();
        drive(1, 2, 0, 1, 1, 1, 1);
        drive(0, 0, 5, 3, 0, 0, 0);
        check("z_stall", int'(bus.stall), 0);
        check("z_fd",    int'({bus.fwd_d_rs, bus.fwd_d_rt}), 0);
        drive(8, 8, 8, 3, 1, 1, 1);
        drive(8, 8, 5, 3, 0, 0, 0);
        check("nw_stall", int'(bus.stall), 0);
        check("nw_fd_rt", int'(bus.fwd_d_rt), 0);
        check("nw_w_we0", int'(bus.w_we), 0);
        nop();
        check("nw_w_we1", int'(bus.w_we), 0);
        nop();
        check("nw_w_we2", int'(bus.w_we), 0);
        check("nw_fe",    int'({bus.fwd_e_rs, bus.fwd_e_rt, bus.fwd_m_rt}), 0);

        // Double match: E and M both produce $8 with Tnew 0
        flush();
        drive(1, 2, 8, 1, 1, 3, 3);
        drive(0, 0, 8, 1, 0, 3, 3);
        drive(8, 0, 0, 3, 0, 1, 3);
        check("dm_stall", int'(bus.stall), 0);
        check("dm_fd_rs", int'(bus.fwd_d_rs), 1);

        // Reset during a load-use stall
        flush();
        drive(1, 8, 0, 0, 2, 1, 3);
        drive(8, 8, 9, 1, 1, 1, 1);
        check("mr_stall_before", int'(bus.stall), 1);
        reset = 1'b0;
        #1;
        clear_model();
        check("mr_stall_now", int'(bus.stall), 0);
        check("mr_w_we",      int'(bus.w_we), 0);
        @(negedge clk);
        set_in(0, 0, 0, 3, 0, 3, 3);
        reset = 1'b1;
        drive(8, 8, 0, 3, 0, 0, 0);
        check("mr_after_stall", int'(bus.stall), 0);
        check("mr_after_fwd",   int'({bus.fwd_d_rs, bus.fwd_d_rt, bus.fwd_e_rs, bus.fwd_e_rt}), 0);
        check("mr_after_w_dst", int'(bus.w_dst), 0);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            drive(pick_reg(), pick_reg(), pick_reg(), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        check("max_stall_run_le2", (max_run <= 2) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
